// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the N:1 pipelined selector: select-width helper and skid-buffer states.
// States are encoded as {main_v, skid_v} so the occupancy bits fall straight out of the state register.
package mux_pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b10;
   localparam logic [1:0] ST_FULL  = 2'b11;

   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_skid_reg.sv
// 2-entry skid buffer: main register drives the outputs, skid register absorbs one word of stall.
// Latency 1 cycle; in_rdy is a register (= !skid occupied), so no out_rdy -> in_rdy combinational path.
module mux_skid_reg
   import mux_pipe_pkg::*;
#(
   parameter int DW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] in_dat,
   input  logic          in_vld,
   output logic          in_rdy,
   output logic [DW-1:0] out_dat,
   output logic          out_vld,
   input  logic          out_rdy
);

   logic [1:0]    st, st_nxt;
   logic [DW-1:0] main_q, main_nxt;
   logic [DW-1:0] skid_q, skid_nxt;
   logic          rdy_q;
   logic          acc, ofire;

   assign acc     = in_vld & rdy_q;
   assign ofire   = st[1] & out_rdy;
   assign in_rdy  = rdy_q;
   assign out_vld = st[1];
   assign out_dat = main_q;

   always_comb begin
      st_nxt   = st;
      main_nxt = main_q;
      skid_nxt = skid_q;
      case (st)
         ST_EMPTY: begin
            if (acc) begin
               st_nxt   = ST_ONE;
               main_nxt = in_dat;
            end
         end
         ST_ONE: begin
            if (acc && !ofire) begin
               st_nxt   = ST_FULL;
               skid_nxt = in_dat;
            end else if (acc) begin
               main_nxt = in_dat;
            end else if (ofire) begin
               // Zero the idle word so out_data and the err flag read 0 when empty.
               st_nxt   = ST_EMPTY;
               main_nxt = '0;
            end
         end
         ST_FULL: begin
            if (ofire) begin
               st_nxt   = ST_ONE;
               main_nxt = skid_q;
            end
         end
         default: begin
            st_nxt   = ST_EMPTY;
            main_nxt = '0;
            skid_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= ST_EMPTY;
         main_q <= '0;
         skid_q <= '0;
         rdy_q  <= 1'b0;
      end else begin
         st     <= st_nxt;
         main_q <= main_nxt;
         skid_q <= skid_nxt;
         rdy_q  <= ~st_nxt[0];
      end
   end

endmodule

// File: rtl/mux_pipe_n.sv
// NUM_IN:1 word selector with registered valid/ready output; out-of-range select passes input 0 and flags sel_err.
// Latency 1 cycle, full throughput; in_ready drops only when the skid entry is occupied.
module mux_pipe_n
   import mux_pipe_pkg::*;
#(
   parameter int WIDTH  = 5,
   parameter int NUM_IN = 2,
   parameter int SEL_W  = sel_width(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sel_err
);

   logic [WIDTH-1:0] sel_word;
   logic             sel_bad;
   logic [WIDTH:0]   skid_out;

   always_comb begin
      sel_word = in_data[0 +: WIDTH];
      for (int k = 1; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) sel_word = in_data[k*WIDTH +: WIDTH];
      end
      sel_bad = (int'(in_sel) >= NUM_IN);
   end

   mux_skid_reg #(
      .DW (WIDTH + 1)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_dat  ({sel_bad, sel_word}),
      .in_vld  (in_valid),
      .in_rdy  (in_ready),
      .out_dat (skid_out),
      .out_vld (out_valid),
      .out_rdy (out_ready)
   );

   assign out_data = skid_out[WIDTH-1:0];
   assign sel_err  = skid_out[WIDTH];

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: three parameterisations, queue scoreboard fed from accepted inputs, negedge monitor.
module tb_mux_pipe_n;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Instance A: WIDTH=5, NUM_IN=2
   logic [9:0]  a_data;  logic       a_sel;  logic a_iv, a_ir, a_ov, a_or, a_err;
   logic [4:0]  a_od;
   // Instance B: WIDTH=8, NUM_IN=3
   logic [23:0] b_data;  logic [1:0] b_sel;  logic b_iv, b_ir, b_ov, b_or, b_err;
   logic [7:0]  b_od;
   // Instance C: WIDTH=32, NUM_IN=4
   logic [127:0] c_data; logic [1:0] c_sel;  logic c_iv, c_ir, c_ov, c_or, c_err;
   logic [31:0] c_od;

   mux_pipe_n #(.WIDTH(5), .NUM_IN(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_valid(a_iv),
      .in_ready(a_ir), .out_data(a_od), .out_valid(a_ov), .out_ready(a_or), .sel_err(a_err));
   mux_pipe_n #(.WIDTH(8), .NUM_IN(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_valid(b_iv),
      .in_ready(b_ir), .out_data(b_od), .out_valid(b_ov), .out_ready(b_or), .sel_err(b_err));
   mux_pipe_n #(.WIDTH(32), .NUM_IN(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_sel(c_sel), .in_valid(c_iv),
      .in_ready(c_ir), .out_data(c_od), .out_valid(c_ov), .out_ready(c_or), .sel_err(c_err));

   int checks = 0;
   int errors = 0;

   // Scoreboard entries: bit 32 = expected sel_err, bits 31:0 = expected word.
   logic [32:0] sb [3][$];
   bit          stall [3];
   logic [32:0] hold [3];

   task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: the chosen word is input[sel] if sel names a real input, else input 0.
   function automatic logic [32:0] model(input logic [127:0] d, input int n, input int w,
                                         input int sel);
      int           idx;
      logic [127:0] sh;
      logic [32:0]  r;
      idx   = (sel < n) ? sel : 0;
      sh    = d >> (idx * w);
      r     = {1'b0, sh[31:0] & ((32'h1 << w) - 32'h1)};
      r[32] = (sel >= n);
      return r;
   endfunction

   task automatic mon(input int id, input logic ov, input logic orr, input logic [32:0] act);
      logic [32:0] e;
      if (stall[id]) begin
         check($sformatf("hold_vld%0d", id), {32'h0, ov}, 33'h1);
         if (ov) check($sformatf("hold_dat%0d", id), act, hold[id]);
      end
      if (ov && orr) begin
         if (sb[id].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious%0d: got %h expected no output at %0t", id, act, $time);
         end else begin
            e = sb[id].pop_front();
            check($sformatf("data%0d", id), act, e);
         end
      end
      stall[id] = ov && !orr;
      hold[id]  = act;
   endtask

   // Outputs are checked before the inputs that fire on the same edge are enqueued.
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            sb[i].delete();
            stall[i] = 1'b0;
         end
      end else begin
         mon(0, a_ov, a_or, {a_err, 27'h0, a_od});
         mon(1, b_ov, b_or, {b_err, 24'h0, b_od});
         mon(2, c_ov, c_or, {c_err, c_od});
         if (a_iv && a_ir) sb[0].push_back(model(128'(a_data), 2, 5, int'(a_sel)));
         if (b_iv && b_ir) sb[1].push_back(model(128'(b_data), 3, 8, int'(b_sel)));
         if (c_iv && c_ir) sb[2].push_back(model(c_data, 4, 32, int'(c_sel)));
      end
   end

   task automatic wait_acc(input int id);
      bit fired;
      fired = 1'b0;
      for (int k = 0; k < 50 && !fired; k++) begin
         @(negedge clk);
         fired = (id == 0) ? a_ir : (id == 1) ? b_ir : c_ir;
         @(posedge clk);
         #1;
      end
      if (!fired) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout%0d: got no accept expected accept within 50 cycles", id);
      end
   endtask

   task automatic send_a(input logic [4:0] w);
      a_data = {5'h00, w};
      a_sel  = 1'b0;
      a_iv   = 1'b1;
      wait_acc(0);
      a_iv   = 1'b0;
   endtask

   initial begin
      bit fired;
      rst_n = 1'b0;
      a_data = '0; a_sel = '0; a_iv = 1'b0; a_or = 1'b0;
      b_data = '0; b_sel = '0; b_iv = 1'b0; b_or = 1'b0;
      c_data = '0; c_sel = '0; c_iv = 1'b0; c_or = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ov", {32'h0, a_ov}, 33'h0);
      check("rst_od", {28'h0, a_od}, 33'h0);
      check("rst_err", {32'h0, a_err}, 33'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_ir", {32'h0, a_ir}, 33'h1);

      // Back-to-back selects, no bubble
      a_data = {5'h1F, 5'h03};
      a_or   = 1'b1;
      a_iv   = 1'b1;
      a_sel  = 1'b1;
      @(posedge clk);
      #1;
      check("b2b_first", {27'h0, a_ov, a_od}, {27'h0, 1'b1, 5'h1F});
      a_sel = 1'b0;
      @(posedge clk);
      #1;
      check("b2b_second", {27'h0, a_ov, a_od}, {27'h0, 1'b1, 5'h03});
      a_iv = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Stall: two words fill the buffer, third waits upstream
      a_or = 1'b0;
      send_a(5'h0A);
      send_a(5'h0B);
      check("full_ir", {32'h0, a_ir}, 33'h0);
      a_data = {5'h00, 5'h0C};
      a_iv   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("full_ir_hold", {32'h0, a_ir}, 33'h0);
      a_or = 1'b1;
      wait_acc(0);
      a_iv = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Out-of-range select on the 3-input instance
      b_or   = 1'b1;
      b_data = {8'h33, 8'h22, 8'h11};
      b_sel  = 2'd3;
      b_iv   = 1'b1;
      wait_acc(1);
      b_iv = 1'b0;
      check("oor_word", {24'h0, b_err, b_od}, {24'h0, 1'b1, 8'h11});
      @(posedge clk);
      #1;
      check("oor_pulse_end", {32'h0, b_err}, 33'h0);
      b_sel = 2'd2;
      b_iv  = 1'b1;
      wait_acc(1);
      b_iv = 1'b0;
      check("sel2_word", {24'h0, b_err, b_od}, {24'h0, 1'b0, 8'h33});
      repeat (3) @(posedge clk);
      #1;

      // Reset while FULL: buffered words must vanish
      a_or = 1'b0;
      send_a(5'h05);
      send_a(5'h06);
      rst_n = 1'b0;
      #1;
      check("arst_ov", {32'h0, a_ov}, 33'h0);
      check("arst_od", {28'h0, a_od}, 33'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      a_or  = 1'b1;
      @(posedge clk);
      #1;
      check("arst_ir", {32'h0, a_ir}, 33'h1);
      repeat (4) @(posedge clk);
      #1;

      // Random traffic on the 32-bit 4-input instance
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         fired = c_iv && c_ir;
         @(posedge clk);
         #1;
         if (!c_iv || fired) begin
            c_iv   = ($urandom_range(0, 3) != 0);
            c_sel  = 2'($urandom_range(0, 3));
            c_data = {$urandom, $urandom, $urandom, $urandom};
         end
         c_or = ($urandom_range(0, 3) != 0);
      end
      c_iv = 1'b0;
      c_or = 1'b1;
      for (int k = 0; k < 50 && (sb[2].size() != 0 || c_ov); k++) @(posedge clk);
      #1;
      check("drain_c", 33'(sb[2].size()), 33'h0);
      check("drain_a", 33'(sb[0].size()), 33'h0);
      check("drain_b", 33'(sb[1].size()), 33'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
